// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions: frame width, mode-0 clock constants, frame FSM states.
package spi_slave_pkg;

    localparam int   SPI_WIDTH = 8;
    localparam int   SPI_CNT_W = $clog2(SPI_WIDTH);
    localparam logic SPI_CPOL  = 1'b0;
    localparam logic SPI_CPHA  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } frame_state_e;

    // Byte that goes into the TX shifter at a frame/byte boundary.
    function automatic logic [SPI_WIDTH-1:0] pick_tx_byte(
        input logic                 hold_empty,
        input logic [SPI_WIDTH-1:0] hold,
        input logic [SPI_WIDTH-1:0] idle_byte
    );
        return hold_empty ? idle_byte : hold;
    endfunction

endpackage

// File: rtl/spi_slave_sync_edge_det.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
module spi_slave_sync_edge_det #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the pin through the chain and keep a copy of the last stage for edge compare.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder running entirely in the clk domain.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | CS high, MISO held low, waiting for CS fall
//  ST_LOAD  | first cycle after CS fall, reply byte just loaded
//  ST_SHIFT | frame active, shifting on SCLK edges until CS rises
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int                   SYNC_STAGES = 2,
    parameter logic [SPI_WIDTH-1:0] IDLE_BYTE   = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 CS,
    input  logic                 SCLK,
    input  logic                 MOSI,
    output logic                 MISO,
    input  logic [SPI_WIDTH-1:0] tx_data,
    input  logic                 tx_load,
    output logic                 tx_ready,
    output logic [SPI_WIDTH-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 overrun,
    output logic                 frame_err,
    output logic                 busy
);
    localparam logic                 SAMPLE_ON_FALL = SPI_CPOL ^ SPI_CPHA;
    localparam logic [SPI_CNT_W-1:0] LAST_BIT       = SPI_CNT_W'(SPI_WIDTH - 1);

    logic cs_rise, cs_fall, sclk_rise, sclk_fall;
    logic sample_evt, shift_evt;

    logic [SYNC_STAGES-1:0] mosi_sync_q;

    frame_state_e           state_q;
    logic [SPI_CNT_W-1:0]   bit_cnt_q;
    logic [SPI_WIDTH-1:0]   rx_shift_q;
    logic [SPI_WIDTH-1:0]   tx_shift_q;
    logic [SPI_WIDTH-1:0]   hold_q;
    logic                   tx_ready_q;
    logic [SPI_WIDTH-1:0]   rx_data_q;
    logic                   rx_valid_q;
    logic                   overrun_q;
    logic                   frame_err_q;
    logic                   miso_q;

    logic [SPI_WIDTH-1:0]   rx_byte_d;
    logic [SPI_WIDTH-1:0]   reload_d;

    spi_slave_sync_edge_det #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_cs_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (CS),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    spi_slave_sync_edge_det #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (SPI_CPOL)
    ) u_sclk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (SCLK),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    // MOSI gets the same depth as SCLK so the data bit lines up with the detected edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        end
    end

    assign sample_evt = SAMPLE_ON_FALL ? sclk_fall : sclk_rise;
    assign shift_evt  = SAMPLE_ON_FALL ? sclk_rise : sclk_fall;
    assign rx_byte_d  = {rx_shift_q[SPI_WIDTH-2:0], mosi_sync_q[SYNC_STAGES-1]};
    assign reload_d   = pick_tx_byte(tx_ready_q, hold_q, IDLE_BYTE);

    // Frame FSM with shifters, TX holding register and RX handshake flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            tx_ready_q  <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;

            if (rx_ack) begin
                rx_valid_q <= 1'b0;
                overrun_q  <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    miso_q    <= 1'b0;
                    bit_cnt_q <= '0;
                    if (cs_fall) begin
                        tx_shift_q <= reload_d;
                        miso_q     <= reload_d[SPI_WIDTH-1];
                        tx_ready_q <= 1'b1;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD, ST_SHIFT: begin
                    if (state_q == ST_LOAD) begin
                        state_q <= ST_SHIFT;
                    end
                    // CS rise wins over a coincident SCLK edge: a frame that ends with
                    // SCLK returning low must not trigger a byte-boundary reload.
                    if (cs_rise) begin
                        if (bit_cnt_q != '0) begin
                            frame_err_q <= 1'b1;
                        end
                        bit_cnt_q  <= '0;
                        rx_shift_q <= '0;
                        miso_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else if (sample_evt) begin
                        rx_shift_q <= rx_byte_d;
                        bit_cnt_q  <= bit_cnt_q + SPI_CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_data_q  <= rx_byte_d;
                            rx_valid_q <= 1'b1;
                            if (rx_valid_q && !rx_ack) begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end else if (shift_evt) begin
                        if (bit_cnt_q != '0) begin
                            miso_q <= tx_shift_q[LAST_BIT - bit_cnt_q];
                        end else begin
                            tx_shift_q <= reload_d;
                            miso_q     <= reload_d[SPI_WIDTH-1];
                            tx_ready_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // A load coincident with a reload lands after the reload sampled the old content.
            if (tx_load) begin
                hold_q     <= tx_data;
                tx_ready_q <= 1'b0;
            end
        end
    end

    assign MISO      = miso_q;
    assign tx_ready  = tx_ready_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
